// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory access unit: request sizes, FSM states, lane indexing.
// Types and constants only; no timing or flow-control behaviour lives here.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // Byte lane = addr[1:0]; half lane = addr[HALF_LANE_BIT].
  localparam int LANE_W        = 2;
  localparam int HALF_LANE_BIT = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_RMW_RD,
    S_RMW_MRG,
    S_RMW_WR,
    S_RESP
  } state_t;

  function automatic logic size_err(input logic [1:0] size, input logic [LANE_W-1:0] lane);
    logic err;
    case (size)
      SZ_HALF: err = lane[0];
      SZ_WORD: err = (lane != '0);
      SZ_ILL:  err = 1'b1;
      default: err = 1'b0;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: load extract/extend and store read-modify-write merge.
// Purely combinational, zero latency; no flow control.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [LANE_W-1:0] lane,
  input  logic [31:0]       rdata,
  input  logic [31:0]       wdata,
  output logic [31:0]       load_data,
  output logic [31:0]       merge_data
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] mask;

  always_comb begin
    if (size == SZ_HALF) shamt = {lane[HALF_LANE_BIT], 4'b0000};
    else                 shamt = {lane, 3'b000};
    shifted   = rdata >> shamt;
    load_data = rdata;
    mask      = '1;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{shifted[7] & ~is_unsigned}}, shifted[7:0]};
        mask      = 32'h0000_00ff << shamt;
      end
      SZ_HALF: begin
        load_data = {{16{shifted[15] & ~is_unsigned}}, shifted[15:0]};
        mask      = 32'h0000_ffff << shamt;
      end
      default: ;
    endcase
    // Word accesses have a full mask, so the merge degenerates to the store data.
    merge_data = (rdata & ~mask) | ((wdata << shamt) & mask);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store sequencer onto a single-port synchronous memory, all outputs registered.
// Latency: error 1, word store 2, load 3, sub-word store 4 cycles; one request in flight, no response backpressure.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_wn,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_read_data
);

  state_t            state;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [LANE_W-1:0] lane_q;
  logic [DATA_W-1:0] wdata_q;
  logic [31:0]       load_data;
  logic [31:0]       merge_data;

  mem_lane_align u_align (
    .size        (size_q),
    .is_unsigned (uns_q),
    .lane        (lane_q),
    .rdata       (mem_read_data),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merge_data  (merge_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_err       <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_wn         <= 1'b0;
      mem_rd         <= 1'b0;
      size_q         <= SZ_BYTE;
      uns_q          <= 1'b0;
      lane_q         <= '0;
      wdata_q        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready   <= 1'b0;
            size_q      <= req_size;
            uns_q       <= req_unsigned;
            lane_q      <= req_addr[LANE_W-1:0];
            wdata_q     <= req_wdata;
            mem_address <= {2'b00, req_addr[ADDR_W-1:2]};
            if (size_err(req_size, req_addr[LANE_W-1:0])) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (!req_we) begin
              state  <= S_RD;
              mem_rd <= 1'b1;
            end else if (req_size == SZ_WORD) begin
              state          <= S_WR;
              mem_wn         <= 1'b1;
              mem_write_data <= req_wdata;
            end else begin
              state  <= S_RMW_RD;
              mem_rd <= 1'b1;
            end
          end
        end
        S_RD: begin
          mem_rd <= 1'b0;
          state  <= S_CAP;
        end
        S_CAP: begin
          resp_rdata <= load_data;
          resp_valid <= 1'b1;
          state      <= S_RESP;
        end
        S_WR: begin
          mem_wn         <= 1'b0;
          mem_write_data <= '0;
          resp_valid     <= 1'b1;
          state          <= S_RESP;
        end
        S_RMW_RD: begin
          mem_rd <= 1'b0;
          state  <= S_RMW_MRG;
        end
        S_RMW_MRG: begin
          // Read data is valid this cycle; the merged word is written next cycle.
          mem_write_data <= merge_data;
          mem_wn         <= 1'b1;
          state          <= S_RMW_WR;
        end
        S_RMW_WR: begin
          mem_wn         <= 1'b0;
          mem_write_data <= '0;
          resp_valid     <= 1'b1;
          state          <= S_RESP;
        end
        S_RESP: begin
          resp_valid  <= 1'b0;
          resp_err    <= 1'b0;
          resp_rdata  <= '0;
          mem_address <= '0;
          req_ready   <= 1'b1;
          state       <= S_IDLE;
        end
        default: begin
          state          <= S_IDLE;
          req_ready      <= 1'b1;
          resp_valid     <= 1'b0;
          resp_rdata     <= '0;
          resp_err       <= 1'b0;
          mem_address    <= '0;
          mem_write_data <= '0;
          mem_wn         <= 1'b0;
          mem_rd         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random traffic
// against a byte-array reference memory.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_wn, mem_rd;
  logic        mem_init;

  logic [31:0] hw_mem [16];
  logic [7:0]  ref_bytes [64];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_wn         (mem_wn),
    .mem_rd         (mem_rd),
    .mem_read_data  (mem_read_data)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 1) ? 32'h8040_20F0 : (32'h5A00_0000 | 32'(i * 32'h0001_0203));
  endfunction

  // Memory: read data valid the cycle after mem_rd, garbage otherwise.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) hw_mem[i] <= init_word(i);
    end else if (mem_wn) begin
      hw_mem[mem_address[3:0]] <= mem_write_data;
    end
    if (mem_rd) mem_read_data <= hw_mem[mem_address[3:0]];
    else        mem_read_data <= $urandom;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {ref_bytes[w*4+3], ref_bytes[w*4+2], ref_bytes[w*4+1], ref_bytes[w*4]};
  endfunction

  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input string tag,
                         output logic [31:0] got_rdata, output logic [31:0] got_wd);
    logic        err;
    int          nbytes, exp_lat, exp_rd, exp_wn, w;
    logic [31:0] exp_rdata, exp_wd;
    int          rd_n, wn_n, rd_c, wn_c, resp_n, resp_c, both, early, addr_bad;
    logic [31:0] a0, wd, rv, ev;

    nbytes    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err       = (size == 2'd3) || (addr % nbytes != 0);
    exp_lat   = err ? 1 : !we ? 3 : (size == 2'd2) ? 2 : 4;
    exp_rd    = (!err && (!we || size != 2'd2)) ? 1 : 0;
    exp_wn    = (err || !we) ? 0 : (size == 2'd2) ? 1 : 3;
    exp_rdata = '0;
    exp_wd    = '0;
    if (!err && !we) begin
      for (int i = 0; i < nbytes; i++) exp_rdata |= 32'(ref_bytes[addr+i]) << (8*i);
      if (nbytes < 4 && !uns && exp_rdata[8*nbytes-1]) exp_rdata |= 32'hFFFF_FFFF << (8*nbytes);
    end
    if (!err && we) begin
      for (int i = 0; i < nbytes; i++) ref_bytes[addr+i] = wdata[8*i +: 8];
      exp_wd = ref_word(int'(addr) / 4);
    end

    @(negedge clk);
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, " ready_wait"}, {31'd0, req_ready}, 32'd1);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;

    rd_n = 0; wn_n = 0; rd_c = 0; wn_c = 0; resp_n = 0; resp_c = 0;
    both = 0; early = 0; addr_bad = 0; a0 = '0; wd = '0; rv = '0; ev = '0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      if (mem_rd) begin rd_n++; rd_c = k; end
      if (mem_wn) begin wn_n++; wn_c = k; wd = mem_write_data; end
      if (mem_rd && mem_wn) both++;
      if (resp_c == 0 && req_ready) early++;
      if (k == 1) a0 = mem_address;
      else if (resp_c == 0 && mem_address != a0) addr_bad++;
      if (resp_valid) begin
        resp_n++;
        if (resp_c == 0) begin resp_c = k; rv = resp_rdata; ev = {31'd0, resp_err}; end
      end
    end
    got_rdata = rv;
    got_wd    = wd;

    check({tag, " latency"},  32'(resp_c), 32'(exp_lat));
    check({tag, " resp_cnt"}, 32'(resp_n), 32'd1);
    check({tag, " rdata"},    rv, exp_rdata);
    check({tag, " err"},      ev, {31'd0, err});
    check({tag, " rd_cycle"}, 32'(rd_c), 32'(exp_rd));
    check({tag, " rd_cnt"},   32'(rd_n), (exp_rd != 0) ? 32'd1 : 32'd0);
    check({tag, " wn_cycle"}, 32'(wn_c), 32'(exp_wn));
    check({tag, " wn_cnt"},   32'(wn_n), (exp_wn != 0) ? 32'd1 : 32'd0);
    if (exp_wn != 0) check({tag, " wdata"}, wd, exp_wd);
    check({tag, " rd_wn_overlap"}, 32'(both), 32'd0);
    check({tag, " ready_busy"}, 32'(early), 32'd0);
    check({tag, " addr_stable"}, 32'(addr_bad), 32'd0);
    if (!err) check({tag, " mem_address"}, a0, addr >> 2);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, wd;
    logic [7:0]  b;
    logic [31:0] iw;
    int acc, nr, wn_seen, resp_seen, rd_seen;
    int acc_cyc [2];
    logic [31:0] rsp [2];
    logic accept_now;

    for (int w = 0; w < 16; w++) begin
      iw = init_word(w);
      for (int i = 0; i < 4; i++) ref_bytes[w*4+i] = iw[8*i +: 8];
    end
    rst = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset req_ready",   {31'd0, req_ready},  32'd1);
    check("reset resp_valid",  {31'd0, resp_valid}, 32'd0);
    check("reset mem_rd",      {31'd0, mem_rd},     32'd0);
    check("reset mem_wn",      {31'd0, mem_wn},     32'd0);
    check("reset mem_address", mem_address,         32'd0);
    check("reset resp_rdata",  resp_rdata,          32'd0);

    run_req(1'b0, 2'd0, 1'b0, 32'h7, '0, "ldb_signed", rd, wd);
    check("ldb_signed value", rd, 32'hFFFF_FF80);
    run_req(1'b0, 2'd0, 1'b1, 32'h7, '0, "ldb_unsigned", rd, wd);
    check("ldb_unsigned value", rd, 32'h0000_0080);
    run_req(1'b1, 2'd1, 1'b0, 32'h6, 32'h0000_ABCD, "sth", rd, wd);
    check("sth merged", wd, 32'hABCD_20F0);
    run_req(1'b0, 2'd2, 1'b0, 32'h4, '0, "ldw_after_sth", rd, wd);
    check("ldw_after_sth value", rd, 32'hABCD_20F0);
    run_req(1'b0, 2'd2, 1'b0, 32'h2, '0, "ldw_misaligned", rd, wd);
    run_req(1'b1, 2'd3, 1'b0, 32'h8, 32'h1234_5678, "illegal_size", rd, wd);

    // Reset arriving while a byte store sits in its merge cycle.
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd0; req_addr = 32'h4; req_wdata = 32'h55; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_rmw rd_issued", {31'd0, mem_rd}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_rmw req_ready",  {31'd0, req_ready},  32'd1);
    check("rst_rmw mem_wn",     {31'd0, mem_wn},     32'd0);
    check("rst_rmw resp_valid", {31'd0, resp_valid}, 32'd0);
    wn_seen = 0; resp_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (mem_wn) wn_seen++;
      if (resp_valid) resp_seen++;
    end
    check("rst_rmw late_wn",   32'(wn_seen),   32'd0);
    check("rst_rmw late_resp", 32'(resp_seen), 32'd0);
    check("rst_rmw word1",     hw_mem[1],      ref_word(1));

    // Reset wins over a simultaneous request.
    @(negedge clk);
    req_we = 1'b0; req_size = 2'd2; req_addr = 32'h4; req_valid = 1'b1; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    check("rst_vs_req ready", {31'd0, req_ready}, 32'd1);
    rd_seen = 0; resp_seen = 0;
    for (int k = 0; k < 5; k++) begin
      if (mem_rd) rd_seen++;
      if (resp_valid) resp_seen++;
      @(negedge clk);
    end
    check("rst_vs_req no_rd",   32'(rd_seen),   32'd0);
    check("rst_vs_req no_resp", 32'(resp_seen), 32'd0);

    run_req(1'b1, 2'd2, 1'b0, 32'h4, 32'hDEAD_BEEF, "stw", rd, wd);
    check("stw data", wd, 32'hDEAD_BEEF);
    run_req(1'b0, 2'd2, 1'b0, 32'h4, '0, "ldw_after_stw", rd, wd);

    // req_valid held across two word loads; address changes while busy.
    @(negedge clk);
    req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h4; req_valid = 1'b1;
    acc = 0; nr = 0; acc_cyc[0] = 0; acc_cyc[1] = 0; rsp[0] = '0; rsp[1] = '0;
    for (int c = 0; c < 30; c++) begin
      if (resp_valid) begin
        if (nr < 2) rsp[nr] = resp_rdata;
        nr++;
      end
      accept_now = req_valid && req_ready;
      if (accept_now) begin
        if (acc < 2) acc_cyc[acc] = c;
        acc++;
      end
      @(posedge clk);
      @(negedge clk);
      if (accept_now) begin
        req_addr = 32'h0;
        if (acc >= 2) req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check("b2b accepts",  32'(acc), 32'd2);
    check("b2b gap",      32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
    check("b2b resp_cnt", 32'(nr), 32'd2);
    check("b2b first",    rsp[0], ref_word(1));
    check("b2b second",   rsp[1], ref_word(0));

    for (int n = 0; n < 250; n++) begin
      logic        we, uns;
      logic [1:0]  sz;
      logic [31:0] a;
      we  = 1'($urandom);
      uns = 1'($urandom);
      sz  = 2'($urandom_range(0, 3));
      a   = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a = a & 32'h3E;
        if (sz == 2'd2) a = a & 32'h3C;
      end
      run_req(we, sz, uns, a, $urandom, "rand", rd, wd);
    end

    for (int w = 0; w < 16; w++) begin
      b = 8'(w);
      check({"final_mem_", string'(8'h30 + b)}, hw_mem[w], ref_word(w));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
